jt89_noise: RTL and testbench

Noise channel generator for the JT89 SN76489-compatible PSG. It holds the noise control register and a 15-bit LFSR, derives the shift clock from an internal prescaler or from tone channel 2, and applies 2 dB-step attenuation. It produces the signed 10-bit `noise` sample consumed by the channel mixer alongside `ch0`..`ch2`.

---
 rtl/jt89_noise.sv | 148 ++++++++++++++
 tb/tb_jt89_noise.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jt89_noise.sv
// jt89_noise: SN76489-compatible noise channel.
// 15-bit LFSR stepped by a prescaled rate counter or by tone channel 2.
module jt89_noise #(
    parameter logic [14:0] SEED = 15'h4000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       wr,
    input  logic [2:0] din,
    input  logic [3:0] vol,
    input  logic       tone2,
    output logic [9:0] noise
);

    localparam logic [1:0] RATE_T2 = 2'b11;
    localparam logic [6:0] LEN_RST = 7'd16;

    logic [2:0]  ctrl;
    logic [14:0] lfsr;
    logic [3:0]  presc;
    logic [6:0]  cnt;
    logic        sff;
    logic        tone2_d;

    logic        tick;
    logic        cnt_end;
    logic        use_t2;
    logic        sff_rise;
    logic        t2_rise;
    logic        shift;
    logic        fb;
    logic [9:0]  amp;

    // Half-period length of the shift flip-flop for a given rate code.
    // Rate 11 does not use the counter, so any legal reload works there.
    function automatic logic [6:0] rate_len(input logic [1:0] r);
        logic [6:0] len;
        unique case (r)
            2'b00:   len = 7'd16;
            2'b01:   len = 7'd32;
            2'b10:   len = 7'd64;
            default: len = 7'd16;
        endcase
        return len;
    endfunction

    // Shift event decode: sff rising edge or a cen-qualified tone2 edge.
    always_comb begin
        tick     = cen && (presc == 4'hF);
        cnt_end  = tick && (cnt == 7'd1);
        use_t2   = (ctrl[1:0] == RATE_T2);
        sff_rise = cnt_end && !sff;
        t2_rise  = cen && tone2 && !tone2_d;
        shift    = use_t2 ? t2_rise : sff_rise;
        fb       = ctrl[2] ? (lfsr[0] ^ lfsr[1]) : lfsr[0];
    end

    // Control register; a write takes effect regardless of cen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl <= 3'd0;
        end else if (wr) begin
            ctrl <= din;
        end
    end

    // Prescaler: one tick every 16 cen pulses, restarted by a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= 4'd0;
        end else if (wr) begin
            presc <= 4'd0;
        end else if (cen) begin
            presc <= presc + 4'd1;
        end
    end

    // Rate counter and shift flip-flop; sff toggles each half period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= LEN_RST;
            sff <= 1'b0;
        end else if (wr) begin
            cnt <= rate_len(din[1:0]);
            sff <= 1'b0;
        end else if (tick) begin
            if (cnt == 7'd1) begin
                cnt <= rate_len(ctrl[1:0]);
                sff <= ~sff;
            end else begin
                cnt <= cnt - 7'd1;
            end
        end
    end

    // tone2 delay flop; only cen cycles can observe an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tone2_d <= 1'b0;
        end else if (cen) begin
            tone2_d <= tone2;
        end
    end

    // LFSR: a write reseeds and suppresses any same-cycle shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (wr) begin
            lfsr <= SEED;
        end else if (shift) begin
            lfsr <= {fb, lfsr[14:1]};
        end
    end

    // Attenuation table, 2 dB per step, last entry silent.
    always_comb begin
        unique case (vol)
            4'd0:  amp = 10'd511;
            4'd1:  amp = 10'd406;
            4'd2:  amp = 10'd322;
            4'd3:  amp = 10'd256;
            4'd4:  amp = 10'd203;
            4'd5:  amp = 10'd162;
            4'd6:  amp = 10'd128;
            4'd7:  amp = 10'd102;
            4'd8:  amp = 10'd81;
            4'd9:  amp = 10'd64;
            4'd10: amp = 10'd51;
            4'd11: amp = 10'd41;
            4'd12: amp = 10'd32;
            4'd13: amp = 10'd26;
            4'd14: amp = 10'd20;
            4'd15: amp = 10'd0;
        endcase
    end

    // Registered signed sample: polarity from lfsr[0].
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            noise <= 10'd0;
        end else begin
            noise <= lfsr[0] ? amp : (10'd0 - amp);
        end
    end

endmodule

// File: tb/tb_jt89_noise.sv
// tb_jt89_noise: scoreboard bench for the JT89 noise channel.
// Stimulus queues expected samples; a monitor compares on each cycle.
module tb_jt89_noise;

    localparam logic [14:0] SEED = 15'h4000;
    localparam logic [9:0] AMP [16] = '{
        10'd511, 10'd406, 10'd322, 10'd256, 10'd203, 10'd162, 10'd128,
        10'd102, 10'd81, 10'd64, 10'd51, 10'd41, 10'd32, 10'd26, 10'd20,
        10'd0
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen;
    logic       wr;
    logic [2:0] din;
    logic [3:0] vol;
    logic       tone2;
    logic [9:0] noise;

    jt89_noise #(.SEED(SEED)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .wr    (wr),
        .din   (din),
        .vol   (vol),
        .tone2 (tone2),
        .noise (noise)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         q_at[$];
    logic [9:0] q_val[$];
    string      q_tag[$];

    int   n_chk = 0;
    int   n_fail = 0;
    bit   done = 1'b0;
    bit   fin_ck = 1'b0;

    logic [14:0] m;
    logic        mfb;

    function automatic logic [9:0] exp_noise(input logic [14:0] s,
                                             input logic [3:0] v);
        return s[0] ? AMP[v] : (10'd0 - AMP[v]);
    endfunction

    task automatic push(input int at, input logic [9:0] val,
                        input string tag);
        q_at.push_back(at);
        q_val.push_back(val);
        q_tag.push_back(tag);
    endtask

    // One clock edge with the inputs already driven; sh says whether
    // this edge is a shift event by the hand-derived schedule.
    task automatic step(input bit sh, input string tag);
        push(cyc + 1, exp_noise(m, vol), tag);
        if (wr) m = SEED;
        else if (sh) m = {(mfb ? (m[0] ^ m[1]) : m[0]), m[14:1]};
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            push(cyc + 1, 10'd0, "reset");
            m   = SEED;
            mfb = 1'b0;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic tone_shift(input string tag);
        cen   = 1'b1;
        tone2 = 1'b1;
        step(1'b1, tag);
        tone2 = 1'b0;
        step(1'b0, tag);
    endtask

    // Continuous cen: first shift h edges after the load, then every 2h.
    task automatic run_sched(input int h, input int n, input string tag);
        cen = 1'b1;
        wr  = 1'b0;
        for (int i = 1; i <= n; i++)
            step((i >= h) && (((i - h) % (2 * h)) == 0), tag);
    endtask

    task automatic run_rate(input logic [2:0] d, input int n,
                            input string tag);
        wr  = 1'b1;
        din = d;
        cen = 1'b1;
        mfb = d[2];
        step(1'b0, tag);
        run_sched(256 << d[1:0], n, tag);
    endtask

    always @(negedge clk) begin
        while (q_at.size() > 0 && q_at[0] <= cyc) begin
            int         at;
            logic [9:0] val;
            string      tag;
            at  = q_at.pop_front();
            val = q_val.pop_front();
            tag = q_tag.pop_front();
            n_chk++;
            if (at != cyc) begin
                n_fail++;
                $display("FAIL %s: slot %0d unchecked at cycle %0d",
                         tag, at, cyc);
            end else if (noise !== val) begin
                n_fail++;
                $display("FAIL %s @%0d: noise=%0d required %0d",
                         tag, cyc, $signed(noise), $signed(val));
            end
        end
        if (done && !fin_ck) begin
            fin_ck = 1'b1;
            n_chk++;
            if (q_at.size() != 0) begin
                n_fail++;
                $display("FAIL leftover: %0d pending, required 0",
                         q_at.size());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        cen   = 1'b0;
        wr    = 1'b0;
        din   = 3'd0;
        vol   = 4'd0;
        tone2 = 1'b0;
        m     = SEED;
        mfb   = 1'b0;
        @(posedge clk);
        #1;
        do_reset(3);
        step(1'b0, "release");
        step(1'b0, "idle");
        step(1'b0, "idle");

        for (int v = 0; v < 16; v++) begin
            vol = 4'(v);
            step(1'b0, "vol_neg");
        end
        vol = 4'd0;

        wr  = 1'b1;
        din = 3'b011;
        cen = 1'b1;
        mfb = 1'b0;
        step(1'b0, "wr11");
        wr = 1'b0;
        repeat (5) tone_shift("t2");

        tone2 = 1'b1;
        step(1'b1, "t2_hold");
        repeat (600) step(1'b0, "t2_hold");

        cen   = 1'b0;
        tone2 = 1'b0;
        step(1'b0, "t2_nocen");
        tone2 = 1'b1;
        step(1'b0, "t2_nocen");
        tone2 = 1'b0;
        step(1'b0, "t2_nocen");
        cen = 1'b1;
        step(1'b0, "t2_nocen");

        cen   = 1'b0;
        tone2 = 1'b1;
        step(1'b0, "t2_late");
        step(1'b0, "t2_late");
        cen = 1'b1;
        step(1'b1, "t2_late");
        tone2 = 1'b0;
        step(1'b0, "t2_late");

        repeat (7) tone_shift("t2");

        cen = 1'b0;
        for (int v = 0; v < 16; v++) begin
            vol = 4'(v);
            step(1'b0, "vol_pos");
        end
        vol = 4'd0;

        wr    = 1'b1;
        din   = 3'b011;
        tone2 = 1'b1;
        cen   = 1'b1;
        mfb   = 1'b0;
        step(1'b1, "wr_vs_t2");
        wr    = 1'b0;
        tone2 = 1'b0;
        step(1'b0, "wr_vs_t2");
        repeat (14) tone_shift("after_wr");

        vol = 4'd3;
        wr  = 1'b1;
        din = 3'b111;
        mfb = 1'b1;
        cen = 1'b1;
        step(1'b0, "wr_white");
        wr = 1'b0;
        repeat (2000) tone_shift("white");
        vol   = 4'd0;
        tone2 = 1'b0;

        run_rate(3'b000, 255, "r00");
        run_rate(3'b000, 7500, "r00_wr_at_shift");
        run_rate(3'b001, 13900, "r01");
        run_rate(3'b010, 27700, "r10");

        run_rate(3'b000, 300, "r00_pre_rst");
        wr  = 1'b1;
        din = 3'b110;
        cen = 1'b1;
        do_reset(1);
        wr = 1'b0;
        run_sched(256, 7000, "after_rst");

        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
